fifo_delay_sched: RTL

//  Schedules run-time delay changes for the channelizer's delay FIFO. Sits between the

---
 rtl/fifo_delay_sched.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_delay_sched.sv
// Delay-change scheduler for the channelizer delay FIFO: passes samples straight through
// and applies a requested delay only at a frame boundary, then stalls input while it settles.
module fifo_delay_sched #(
  parameter int DATA_WIDTH      = 32,
  parameter int FRAME_LEN_WIDTH = 16,
  parameter int SETTLE_CYCLES   = 3
) (
  input  logic                       clk,
  input  logic                       async_reset_n,
  input  logic                       cfg_tvalid,
  input  logic [8:0]                 cfg_tdata,
  output logic                       cfg_tready,
  input  logic [FRAME_LEN_WIDTH-1:0] frame_len,
  input  logic                       s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  output logic                       s_axis_tready,
  output logic                       fifo_tvalid,
  output logic [DATA_WIDTH-1:0]      fifo_tdata,
  input  logic                       fifo_tready,
  output logic [8:0]                 fifo_delay,
  output logic                       delay_applied,
  output logic                       busy,
  output logic [1:0]                 dbg_state,
  output logic [FRAME_LEN_WIDTH-1:0] dbg_beat_cnt
);

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1.
  // Valid never waits on ready; the fifo side ready/valid are combinational copies of the
  // upstream side, masked only while the FIFO's delay adder settles.

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PENDING = 2'd1,
    ST_SETTLE  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [FRAME_LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [8:0]                 delay_q, delay_d;
  logic [8:0]                 pending_q, pending_d;
  logic [SW-1:0]              settle_cnt_q, settle_cnt_d;

  logic                       gate;
  logic                       beat;
  logic                       last_beat;
  logic                       cfg_accept;
  logic [FRAME_LEN_WIDTH-1:0] last_idx;

  // Zero-latency datapath.
  always_comb begin
    gate          = (state_q == ST_SETTLE);
    fifo_tdata    = s_axis_tdata;
    fifo_tvalid   = s_axis_tvalid & ~gate;
    s_axis_tready = fifo_tready & ~gate;
    beat          = fifo_tvalid & fifo_tready;
  end

  // frame_len of 0 behaves as 1; >= lets a mid-frame shrink end the frame on the next beat.
  always_comb begin
    last_idx  = (frame_len == '0) ? '0 : frame_len - FRAME_LEN_WIDTH'(1);
    last_beat = beat & (beat_cnt_q >= last_idx);
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (beat) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + FRAME_LEN_WIDTH'(1);
    end
  end

  // Next state and outputs.
  always_comb begin
    state_d       = state_q;
    delay_d       = delay_q;
    pending_d     = pending_q;
    settle_cnt_d  = settle_cnt_q;
    cfg_tready    = 1'b0;
    delay_applied = 1'b0;
    busy          = 1'b0;
    cfg_accept    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        cfg_tready = 1'b1;
        cfg_accept = cfg_tvalid;
        // A request equal to the live delay would only cost a stall, so drop it.
        if (cfg_accept && (cfg_tdata != delay_q)) begin
          pending_d = cfg_tdata;
          state_d   = ST_PENDING;
        end
      end
      ST_PENDING: begin
        busy = 1'b1;
        if (last_beat) begin
          delay_d      = pending_q;
          settle_cnt_d = SW'(SETTLE_CYCLES - 1);
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt_q == '0) begin
          delay_applied = 1'b1;
          state_d       = ST_RUN;
        end else begin
          settle_cnt_d = settle_cnt_q - SW'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q      <= ST_RUN;
      beat_cnt_q   <= '0;
      delay_q      <= '0;
      pending_q    <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      delay_q      <= delay_d;
      pending_q    <= pending_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign fifo_delay   = delay_q;
  assign dbg_state    = state_q;
  assign dbg_beat_cnt = beat_cnt_q;

endmodule
